// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard / interrupt / exception steering with an
//            interrupt holdoff FSM. Optional counters: HAZARD_CTRL_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int IRQ_HOLD = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_UseRt,
    input  logic        EX_MemRd,
    input  logic [4:0]  EX_WrReg,
    input  logic        EX_BrTaken,
    input  logic        ID_Jump,
    input  logic        ID_IllOp,
    input  logic [31:0] ID_PC,
    input  logic        irq_req,
    output logic [2:0]  pc_src,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        epc_wr,
    output logic        epc_sel,
    output logic        irq_ack,
    input  logic        stats_clr,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [2:0] c_PC_SEQ  = 3'd0;
    localparam logic [2:0] c_PC_BR   = 3'd1;
    localparam logic [2:0] c_PC_JMP  = 3'd2;
    localparam logic [2:0] c_PC_IRQ  = 3'd3;
    localparam logic [2:0] c_PC_EXC  = 3'd4;
    localparam logic [2:0] c_PC_HOLD = 3'd5;
    localparam logic [3:0] c_HOLD_LOAD = 4'(IRQ_HOLD - 1);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t     r_state;
    logic [3:0] r_hold_cnt;
    logic       w_load_use;
    logic       w_irq_take;

    assign w_load_use = EX_MemRd && (EX_WrReg != 5'd0) &&
                        ((EX_WrReg == ID_rs) || (ID_UseRt && (EX_WrReg == ID_rt)));

    // Kernel-mode PCs (bit 31 set) keep the interrupt pending; it is level held.
    assign w_irq_take = !reset && (r_state == S_RUN) && irq_req && !ID_PC[31] &&
                        !EX_BrTaken && !ID_IllOp;

    always_comb begin
        pc_src      = c_PC_SEQ;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        epc_wr      = 1'b0;
        epc_sel     = 1'b0;
        irq_ack     = 1'b0;
        if (!reset) begin
            if (EX_BrTaken) begin
                pc_src      = c_PC_BR;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (ID_IllOp) begin
                pc_src      = c_PC_EXC;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                epc_wr      = 1'b1;
                epc_sel     = 1'b1;
            end else if (w_irq_take) begin
                pc_src      = c_PC_IRQ;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                epc_wr      = 1'b1;
                irq_ack     = 1'b1;
            end else if (w_load_use) begin
                pc_src      = c_PC_HOLD;
                ifid_hold   = 1'b1;
                idex_bubble = 1'b1;
            end else if (ID_Jump) begin
                pc_src      = c_PC_JMP;
                ifid_flush  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_hold_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_irq_take) begin
                        r_state    <= S_HOLD;
                        r_hold_cnt <= c_HOLD_LOAD;
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt == 4'd0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state    <= S_RUN;
                    r_hold_cnt <= 4'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_CTRL_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        w_unused;

    assign w_unused = ^ID_PC[30:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else if (stats_clr) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (ifid_hold && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (ifid_flush && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    logic w_unused;

    assign w_unused  = ^{stats_clr, ID_PC[30:0]};
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl: directed literal cases plus
//            randomized traffic against a per-cycle behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int IRQ_HOLD = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_rs, ID_rt, EX_WrReg;
    logic        ID_UseRt, EX_MemRd, EX_BrTaken, ID_Jump, ID_IllOp, irq_req, stats_clr;
    logic [31:0] ID_PC;
    logic [2:0]  pc_src;
    logic        ifid_hold, ifid_flush, idex_bubble, epc_wr, epc_sel, irq_ack;
    logic [15:0] stall_cnt, flush_cnt;

    int n_pass  = 0;
    int n_total = 0;

    hazard_ctrl #(.IRQ_HOLD(IRQ_HOLD)) dut (
        .clk(clk), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRt(ID_UseRt),
        .EX_MemRd(EX_MemRd), .EX_WrReg(EX_WrReg),
        .EX_BrTaken(EX_BrTaken), .ID_Jump(ID_Jump), .ID_IllOp(ID_IllOp),
        .ID_PC(ID_PC), .irq_req(irq_req),
        .pc_src(pc_src), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .epc_wr(epc_wr), .epc_sel(epc_sel),
        .irq_ack(irq_ack), .stats_clr(stats_clr),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: number of upcoming cycles in which irq_req is ignored,
    // plus the two statistics counters.
    int ignore_left = 0;
    int m_stall = 0;
    int m_flush = 0;

    always @(negedge clk) begin
        logic [2:0] e_pc;
        logic e_hold, e_flush, e_bub, e_ewr, e_esel, e_ack, lu, irq_ok;
        e_pc = 3'd0; e_hold = 0; e_flush = 0; e_bub = 0; e_ewr = 0; e_esel = 0; e_ack = 0;
        lu = EX_MemRd && EX_WrReg != 0 &&
             (EX_WrReg == ID_rs || (ID_UseRt && EX_WrReg == ID_rt));
        irq_ok = ignore_left == 0 && irq_req && !ID_PC[31];
        if (reset) begin
            ignore_left = 0; m_stall = 0; m_flush = 0;
        end else if (EX_BrTaken) begin
            e_pc = 3'd1; e_flush = 1; e_bub = 1;
        end else if (ID_IllOp) begin
            e_pc = 3'd4; e_flush = 1; e_bub = 1; e_ewr = 1; e_esel = 1;
        end else if (irq_ok) begin
            e_pc = 3'd3; e_flush = 1; e_bub = 1; e_ewr = 1; e_ack = 1;
        end else if (lu) begin
            e_pc = 3'd5; e_hold = 1; e_bub = 1;
        end else if (ID_Jump) begin
            e_pc = 3'd2; e_flush = 1;
        end
        chk("pc_src", 32'(pc_src), 32'(e_pc));
        chk("ifid_hold", 32'(ifid_hold), 32'(e_hold));
        chk("ifid_flush", 32'(ifid_flush), 32'(e_flush));
        chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        chk("epc_wr", 32'(epc_wr), 32'(e_ewr));
        chk("epc_sel", 32'(epc_sel), 32'(e_esel));
        chk("irq_ack", 32'(irq_ack), 32'(e_ack));
        chk("hold_xor_flush", 32'(ifid_hold & ifid_flush), 32'd0);
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        if (!reset) begin
            if (e_ack) ignore_left = IRQ_HOLD;
            else if (ignore_left > 0) ignore_left--;
`ifdef HAZARD_CTRL_STATS_EN
            if (stats_clr) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (e_hold && m_stall < 16'hFFFF) m_stall++;
                if (e_flush && m_flush < 16'hFFFF) m_flush++;
            end
`endif
        end
    end

    task automatic idle_in();
        ID_rs = 0; ID_rt = 0; ID_UseRt = 0; EX_MemRd = 0; EX_WrReg = 0;
        EX_BrTaken = 0; ID_Jump = 0; ID_IllOp = 0; ID_PC = 32'h0040_0000;
        irq_req = 0; stats_clr = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        idle_in();
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    initial begin
        reset = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_pc_src", 32'(pc_src), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        next_cycle();
        reset = 1'b0;

        // Load-use stall on rs
        EX_MemRd = 1; EX_WrReg = 5'd8; ID_rs = 5'd8;
        @(negedge clk);
        chk("lu_pc_src", 32'(pc_src), 32'd5);
        chk("lu_hold", 32'(ifid_hold), 32'd1);
        chk("lu_bubble", 32'(idex_bubble), 32'd1);
        next_cycle();
        idle_in();
        @(negedge clk);
        chk("lu_after_pc_src", 32'(pc_src), 32'd0);
`ifdef HAZARD_CTRL_STATS_EN
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
`else
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        next_cycle();

        // Load to $zero is never a hazard
        EX_MemRd = 1; EX_WrReg = 5'd0; ID_rs = 5'd0;
        @(negedge clk);
        chk("r0_pc_src", 32'(pc_src), 32'd0);
        chk("r0_hold", 32'(ifid_hold), 32'd0);
        next_cycle();

        // Branch beats load-use and irq; irq taken the following cycle
        EX_MemRd = 1; EX_WrReg = 5'd3; ID_rs = 5'd3; EX_BrTaken = 1; irq_req = 1;
        @(negedge clk);
        chk("br_pc_src", 32'(pc_src), 32'd1);
        chk("br_flush", 32'(ifid_flush), 32'd1);
        chk("br_irq_ack", 32'(irq_ack), 32'd0);
        next_cycle();
        EX_BrTaken = 0; EX_MemRd = 0;
        @(negedge clk);
        chk("br_next_ack", 32'(irq_ack), 32'd1);
        chk("br_next_pc_src", 32'(pc_src), 32'd3);
        next_cycle();
        settle(IRQ_HOLD + 1);

        // Held irq: one ack, then blocked for IRQ_HOLD cycles
        irq_req = 1; ID_PC = 32'h0040_0010;
        for (int c = 0; c <= IRQ_HOLD + 1; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("hold_epc_wr", 32'(epc_wr), 32'd1);
                chk("hold_epc_sel", 32'(epc_sel), 32'd0);
            end
            chk("hold_ack_seq", 32'(irq_ack), (c == 0 || c == IRQ_HOLD + 1) ? 32'd1 : 32'd0);
            next_cycle();
        end
        settle(IRQ_HOLD + 1);

        // Kernel PCs keep irq pending until the first user-mode cycle
        irq_req = 1; ID_PC = 32'h8000_0100;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) ID_PC = 32'h0000_0200;
            @(negedge clk);
            chk("kern_ack", 32'(irq_ack), (c == 5) ? 32'd1 : 32'd0);
            next_cycle();
        end
        settle(IRQ_HOLD + 1);

        // Illegal op beats jump
        ID_IllOp = 1; ID_Jump = 1;
        @(negedge clk);
        chk("ill_pc_src", 32'(pc_src), 32'd4);
        chk("ill_epc_sel", 32'(epc_sel), 32'd1);
        chk("ill_bubble", 32'(idex_bubble), 32'd1);
        next_cycle();

        // Reset in the middle of a holdoff
        idle_in();
        irq_req = 1;
        @(negedge clk);
        chk("rh_take", 32'(irq_ack), 32'd1);
        next_cycle();
        reset = 1;
        @(negedge clk);
        chk("rh_rst_ack", 32'(irq_ack), 32'd0);
        chk("rh_rst_flush_cnt", 32'(flush_cnt), 32'd0);
        next_cycle();
        reset = 0;
        @(negedge clk);
        chk("rh_after_ack", 32'(irq_ack), 32'd1);
        next_cycle();
        settle(IRQ_HOLD + 1);

        // Randomized traffic, checked by the per-cycle model
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 149) == 0);
            ID_rs      = 5'($urandom_range(0, 3));
            ID_rt      = 5'($urandom_range(0, 3));
            ID_UseRt   = 1'($urandom_range(0, 1));
            EX_MemRd   = ($urandom_range(0, 2) == 0);
            EX_WrReg   = 5'($urandom_range(0, 3));
            EX_BrTaken = ($urandom_range(0, 7) == 0);
            ID_IllOp   = ($urandom_range(0, 15) == 0);
            ID_Jump    = ($urandom_range(0, 4) == 0);
            irq_req    = ($urandom_range(0, 2) == 0);
            ID_PC      = {1'($urandom_range(0, 1)), 31'($urandom)};
            stats_clr  = ($urandom_range(0, 19) == 0);
            next_cycle();
        end
        reset = 0;
        settle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
